// File: rtl/priority_decoder_3to8_seq_pkg.sv
// Types shared between the 8-to-3 priority encoder and its 3-to-8 replay decoder.
package prienc_pkg;

    localparam int ENC_IN_W  = 3;
    localparam int ENC_OUT_W = 8;

    typedef struct packed {
        logic                enable;
        logic [ENC_IN_W-1:0] code;
    } enc_word_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } dec_state_e;

endpackage

// File: rtl/priority_decoder_3to8_seq_if.sv
// Encoded-code handshake between the priority encoder (master) and the decoder (slave).
interface priority_decoder_3to8_seq_if;
    import prienc_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_enable;
    logic [ENC_IN_W-1:0] in_code;

    modport master (output in_valid, output in_enable, output in_code, input in_ready);
    modport slave  (input in_valid, input in_enable, input in_code, output in_ready);

endinterface

// File: rtl/priority_decoder_3to8_seq_fifo.sv
// Purpose: generic synchronous FIFO, pointer-based, extra wrap bit distinguishes full from empty.
// Latency: write visible on rdata the cycle after push; rdata shows the head combinationally.
// Backpressure: push ignored when full, pop ignored when empty.
module dec_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/priority_decoder_3to8_seq.sv
// Purpose: buffers {enable,code} words and replays each as a PULSE_LEN-cycle one-hot pulse; DEC_GAP_EN adds a 1-cycle zero gap.
// Latency: code accepted at edge N (idle, empty) appears on out_onehot after edge N+1.
// Backpressure: in_ready = !fifo_full from registered count, held low in reset and until the first clock after it.
module priority_decoder_3to8_seq
    import prienc_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 8,
    parameter int PULSE_LEN  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    priority_decoder_3to8_seq_if.slave   up,
    output logic [OUT_W-1:0]             out_onehot,
    output logic                         out_valid,
    output logic                         busy
);

    localparam int CNT_W = 8;
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    enc_word_t  wword;
    enc_word_t  rword;
    dec_state_e state;
    logic [CNT_W-1:0] cnt;
    logic push, pop, full, empty, up_q;

    assign up.in_ready = up_q & ~full;
    assign push        = up.in_valid & up.in_ready;

    // A disabled word may carry an undriven code; store zeros so X never reaches the FIFO.
    assign wword.enable = up.in_enable;
    assign wword.code   = up.in_enable ? up.in_code : '0;

    dec_fifo #(
        .WIDTH ($bits(enc_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wword),
        .rdata (rword),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE, GAP: pop = ~empty;
`ifdef DEC_GAP_EN
            DRIVE:     pop = 1'b0;
`else
            DRIVE:     pop = ~empty && (cnt == '0);
`endif
            default:   pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            up_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_onehot <= rword.enable ? (ONE << rword.code[IN_W-1:0]) : '0;
                        out_valid  <= 1'b1;
                        cnt        <= CNT_W'(PULSE_LEN - 1);
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
`ifdef DEC_GAP_EN
                        out_onehot <= '0;
                        out_valid  <= 1'b0;
                        state      <= GAP;
`else
                        if (pop) begin
                            out_onehot <= rword.enable ? (ONE << rword.code[IN_W-1:0]) : '0;
                            out_valid  <= 1'b1;
                            cnt        <= CNT_W'(PULSE_LEN - 1);
                        end else begin
                            out_onehot <= '0;
                            out_valid  <= 1'b0;
                            state      <= IDLE;
                        end
`endif
                    end
                end
                GAP: begin
                    if (pop) begin
                        out_onehot <= rword.enable ? (ONE << rword.code[IN_W-1:0]) : '0;
                        out_valid  <= 1'b1;
                        cnt        <= CNT_W'(PULSE_LEN - 1);
                        state      <= DRIVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = ~empty | (state != IDLE);

endmodule

// File: tb/tb_priority_decoder_3to8_seq.sv
// Directed bench for priority_decoder_3to8_seq; expectations adapt to whether DEC_GAP_EN is defined.
module tb_priority_decoder_3to8_seq;

`ifdef DEC_GAP_EN
    localparam bit gap_mode = 1'b1;
`else
    localparam bit gap_mode = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       busy;

    always #5 clk = ~clk;

    priority_decoder_3to8_seq_if bus();

    priority_decoder_3to8_seq #(
        .IN_W       (3),
        .OUT_W      (8),
        .PULSE_LEN  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (bus.slave),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int stalls   = 0;
    bit rec_en   = 1'b0;
    logic [8:0] rec_q[$];
    logic [8:0] exp_q[$];

    always @(negedge clk) if (rec_en) rec_q.push_back({out_valid, out_onehot});
    always @(posedge clk) if (rec_en && bus.in_valid && !bus.in_ready) stalls++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic en, input logic [2:0] code);
        int n = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_enable = en;
        bus.in_code   = code;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("send_ready_timeout", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_enable = 1'bx;
        bus.in_code   = 3'bxxx;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'h0);
    endtask

    // Four cycles of the pattern, then one zero cycle when a gap is mandatory or the stream ends.
    task automatic add_pulse(input logic [7:0] pat, input bit last);
        repeat (4) exp_q.push_back({1'b1, pat});
        if (gap_mode || last) exp_q.push_back(9'h000);
    endtask

    task automatic check_stream(input string tag);
        int s = 0;
        logic [8:0] obs;
        while (s < rec_q.size() && !rec_q[s][8]) s++;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (s + i < rec_q.size()) ? rec_q[s + i] : 9'h1ff;
            chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset held with a request offered: nothing may be accepted.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_enable = 1'b1;
        bus.in_code   = 3'd3;
        repeat (3) @(negedge clk);
        chk("rst_onehot", 32'(out_onehot), 32'h00);
        chk("rst_valid",  32'(out_valid),  32'h0);
        chk("rst_ready",  32'(bus.in_ready), 32'h0);
        chk("rst_busy",   32'(busy),       32'h0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_ready_before_clk", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        chk("rel_ready_after_clk", 32'(bus.in_ready), 32'h1);
        chk("rel_busy",  32'(busy),      32'h0);
        chk("rel_valid", 32'(out_valid), 32'h0);

        // Single code 7: one cycle of latency, then 4 cycles of 8'h80.
        send(1'b1, 3'd7);
        idle_in();
        chk("single_latency_valid", 32'(out_valid), 32'h0);
        chk("single_busy", 32'(busy), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("single_onehot_c%0d", k), 32'(out_onehot), 32'h80);
            chk($sformatf("single_valid_c%0d", k),  32'(out_valid),  32'h1);
        end
        @(negedge clk);
        chk("single_end_onehot", 32'(out_onehot), 32'h00);
        chk("single_end_valid",  32'(out_valid),  32'h0);
        @(negedge clk);
        chk("single_end_busy", 32'(busy), 32'h0);

        // Disabled word with an undriven code: zero pulse, valid high, no X anywhere.
        send(1'b0, 3'bxxx);
        idle_in();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("dis_onehot_c%0d", k), 32'(out_onehot), 32'h00);
            chk($sformatf("dis_valid_c%0d", k),  32'(out_valid),  32'h1);
            chk($sformatf("dis_nox_c%0d", k),
                32'($isunknown({out_onehot, out_valid, busy, bus.in_ready})), 32'h0);
        end
        @(negedge clk);
        chk("dis_end_valid", 32'(out_valid), 32'h0);
        wait_idle("dis_idle_timeout");

        // Burst 7..1: FIFO fills after the fifth transfer, ordering and count preserved.
        rec_q.delete();
        exp_q.delete();
        stalls = 0;
        rec_en = 1'b1;
        for (int c = 7; c >= 3; c--) send(1'b1, 3'(c));
        chk("burst_full_ready", 32'(bus.in_ready), 32'h0);
        chk("burst_full_busy",  32'(busy),         32'h1);
        send(1'b1, 3'd2);
        send(1'b1, 3'd1);
        idle_in();
        wait_idle("burst_idle_timeout");
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        chk("burst_backpressure", 32'(stalls > 0), 32'h1);
        add_pulse(8'h80, 1'b0);
        add_pulse(8'h40, 1'b0);
        add_pulse(8'h20, 1'b0);
        add_pulse(8'h10, 1'b0);
        add_pulse(8'h08, 1'b0);
        add_pulse(8'h04, 1'b0);
        add_pulse(8'h02, 1'b1);
        check_stream("burst");

        // Reset in the 2nd cycle of code 5's pulse with codes 1,2,3 still queued.
        send(1'b1, 3'd6);
        send(1'b1, 3'd5);
        send(1'b1, 3'd1);
        send(1'b1, 3'd2);
        send(1'b1, 3'd3);
        idle_in();
        begin
            int n = 0;
            while (out_onehot !== 8'h20 && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        chk("mid_seen_code5", 32'(out_onehot), 32'h20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_onehot", 32'(out_onehot), 32'h00);
        chk("mid_async_valid",  32'(out_valid),  32'h0);
        chk("mid_async_busy",   32'(busy),       32'h0);
        chk("mid_async_ready",  32'(bus.in_ready), 32'h0);
        repeat (2) @(negedge clk);
        rec_q.delete();
        rec_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(bus.in_ready), 32'h1);
        repeat (40) @(negedge clk);
        rec_en = 1'b0;
        begin
            int nv = 0;
            foreach (rec_q[i]) if (rec_q[i][8] !== 1'b0) nv++;
            chk("mid_discarded", 32'(nv), 32'h0);
        end
        chk("mid_idle_busy", 32'(busy), 32'h0);

        // Codes 1 then 2: back-to-back without gap, one zero cycle between with it.
        rec_q.delete();
        exp_q.delete();
        rec_en = 1'b1;
        send(1'b1, 3'd1);
        send(1'b1, 3'd2);
        idle_in();
        wait_idle("pair_idle_timeout");
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        add_pulse(8'h02, 1'b0);
        add_pulse(8'h04, 1'b1);
        check_stream("pair");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
